// File: rtl/rx_atten_ctrl.sv
// rx_atten_ctrl
//   Automatic attenuation controller for the text receiver. It watches the raw
//   received sample stream in windows of WINDOW accepted samples and records
//   the peak of each window. From that peak it picks the attenuation code
//   (16/8/4/2) for the receiver's ATTEN_IN input. Once the code is locked, it
//   only changes after HOLD_WINDOWS consecutive identical differing decisions.
//
// Ports
//   CLK          in   1   system clock, rising edge
//   RESET        in   1   asynchronous, active-low reset
//   START        in   1   begin acquisition (sampled only in IDLE)
//   STOP         in   1   abort and return to IDLE (any state)
//   SAMPLE_VALID in   1   SIGNAL_IN holds a new sample this cycle
//   SIGNAL_IN    in  36   received sample, unsigned
//   ATTEN_OUT    out  5   attenuation code, always 16, 8, 4 or 2
//   ATTEN_VALID  out  1   one-cycle pulse when ATTEN_OUT is written
//   LOCKED       out  1   a decision has been made since the last START
//   BUSY         out  1   controller not in IDLE
//   PEAK_OUT     out 36   peak of the last completed window
module rx_atten_ctrl #(
  parameter int unsigned WINDOW       = 64,
  parameter int unsigned HOLD_WINDOWS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        STOP,
  input  logic        SAMPLE_VALID,
  input  logic [35:0] SIGNAL_IN,
  output logic [4:0]  ATTEN_OUT,
  output logic        ATTEN_VALID,
  output logic        LOCKED,
  output logic        BUSY,
  output logic [35:0] PEAK_OUT
);

  localparam int unsigned CW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [35:0]   peak;
  logic [4:0]    pend_code;
  logic [3:0]    pend_cnt;
  logic [4:0]    cand;
  logic          last_sample;
  logic          hold_met;

  assign last_sample = SAMPLE_VALID && (count == CW'(WINDOW - 1));

  // Widened by one bit so pend_cnt + 1 cannot wrap before the compare.
  assign hold_met = (({1'b0, pend_cnt} + 5'd1) == 5'(HOLD_WINDOWS));

  // Candidate code from the top three bits of the window peak.
  always_comb begin
    cand = 5'd2;
    if (peak[35])      cand = 5'd16;
    else if (peak[34]) cand = 5'd8;
    else if (peak[33]) cand = 5'd4;
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START && !STOP) state_nxt = MEASURE;
      MEASURE: begin
        if (STOP)             state_nxt = IDLE;
        else if (last_sample) state_nxt = DECIDE;
      end
      DECIDE:  state_nxt = STOP ? IDLE : MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY = (state != IDLE);
  end

  // Window datapath and code-update rules
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count       <= '0;
      peak        <= '0;
      pend_code   <= '0;
      pend_cnt    <= '0;
      ATTEN_OUT   <= 5'd16;
      ATTEN_VALID <= 1'b0;
      LOCKED      <= 1'b0;
      PEAK_OUT    <= '0;
    end else begin
      ATTEN_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (START && !STOP) begin
            count <= '0;
            peak  <= '0;
          end
        end
        MEASURE: begin
          if (STOP) begin
            count     <= '0;
            peak      <= '0;
            pend_code <= '0;
            pend_cnt  <= '0;
            LOCKED    <= 1'b0;
          end else if (SAMPLE_VALID) begin
            count <= count + 1'b1;
            if (SIGNAL_IN > peak) peak <= SIGNAL_IN;
          end
        end
        DECIDE: begin
          count <= '0;
          peak  <= '0;
          if (STOP) begin
            pend_code <= '0;
            pend_cnt  <= '0;
            LOCKED    <= 1'b0;
          end else begin
            PEAK_OUT <= peak;
            if (!LOCKED) begin
              ATTEN_OUT   <= cand;
              ATTEN_VALID <= 1'b1;
              LOCKED      <= 1'b1;
              pend_code   <= '0;
              pend_cnt    <= '0;
            end else if (cand == ATTEN_OUT) begin
              pend_cnt <= '0;
            end else if (cand == pend_code) begin
              // pend_cnt may be 0 here if a matching decision interrupted the
              // streak; that is then equivalent to starting a new pending run.
              if (hold_met) begin
                ATTEN_OUT   <= cand;
                ATTEN_VALID <= 1'b1;
                pend_code   <= '0;
                pend_cnt    <= '0;
              end else begin
                pend_cnt <= pend_cnt + 1'b1;
              end
            end else if (HOLD_WINDOWS == 1) begin
              ATTEN_OUT   <= cand;
              ATTEN_VALID <= 1'b1;
              pend_code   <= '0;
              pend_cnt    <= '0;
            end else begin
              pend_code <= cand;
              pend_cnt  <= 4'd1;
            end
          end
        end
        default: begin
          count <= '0;
          peak  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_atten_ctrl.sv
// Directed testbench for rx_atten_ctrl with WINDOW=4 and HOLD_WINDOWS=2.
module tb_rx_atten_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        SAMPLE_VALID = 1'b0;
  logic [35:0] SIGNAL_IN = '0;
  logic [4:0]  ATTEN_OUT;
  logic        ATTEN_VALID;
  logic        LOCKED;
  logic        BUSY;
  logic [35:0] PEAK_OUT;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rx_atten_ctrl #(
    .WINDOW       (4),
    .HOLD_WINDOWS (2)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .STOP         (STOP),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SIGNAL_IN    (SIGNAL_IN),
    .ATTEN_OUT    (ATTEN_OUT),
    .ATTEN_VALID  (ATTEN_VALID),
    .LOCKED       (LOCKED),
    .BUSY         (BUSY),
    .PEAK_OUT     (PEAK_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, settle 1 time unit.
  task automatic tick(input logic v, input logic [35:0] d, input logic st, input logic sp);
    @(negedge CLK);
    SAMPLE_VALID = v;
    SIGNAL_IN    = d;
    START        = st;
    STOP         = sp;
    @(posedge CLK);
    #1;
  endtask

  // Four valid samples, then the DECIDE cycle with an all-ones sample that must be dropped.
  task automatic win4(input logic [35:0] a, input logic [35:0] b,
                      input logic [35:0] c, input logic [35:0] d);
    tick(1'b1, a, 1'b0, 1'b0);
    tick(1'b1, b, 1'b0, 1'b0);
    tick(1'b1, c, 1'b0, 1'b0);
    tick(1'b1, d, 1'b0, 1'b0);
    tick(1'b1, '1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_atten",  36'(ATTEN_OUT), 36'd16);
    check("rst_valid",  36'(ATTEN_VALID), 36'd0);
    check("rst_locked", 36'(LOCKED), 36'd0);
    check("rst_busy",   36'(BUSY), 36'd0);
    check("rst_peak",   PEAK_OUT, 36'd0);
    @(negedge CLK);
    RESET = 1'b1;
    tick(1'b0, '0, 1'b0, 1'b0);
    check("idle_busy", 36'(BUSY), 36'd0);

    // First lock
    tick(1'b0, '0, 1'b1, 1'b0);
    check("start_busy", 36'(BUSY), 36'd1);
    tick(1'b1, 36'd1, 1'b0, 1'b0);
    tick(1'b1, 36'h200000000, 1'b0, 1'b0);
    tick(1'b1, 36'd5, 1'b0, 1'b0);
    tick(1'b1, 36'd0, 1'b0, 1'b0);
    check("lock1_pre_atten", 36'(ATTEN_OUT), 36'd16);
    check("lock1_pre_valid", 36'(ATTEN_VALID), 36'd0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("lock1_atten",  36'(ATTEN_OUT), 36'd4);
    check("lock1_valid",  36'(ATTEN_VALID), 36'd1);
    check("lock1_locked", 36'(LOCKED), 36'd1);
    check("lock1_peak",   PEAK_OUT, 36'h200000000);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("lock1_pulse_end", 36'(ATTEN_VALID), 36'd0);

    // Hysteresis towards 16
    win4(36'd0, 36'h800000000, 36'd1, 36'd0);
    check("hys16a_atten", 36'(ATTEN_OUT), 36'd4);
    check("hys16a_valid", 36'(ATTEN_VALID), 36'd0);
    check("hys16a_peak",  PEAK_OUT, 36'h800000000);
    win4(36'd0, 36'h800000000, 36'd1, 36'd0);
    check("hys16b_atten", 36'(ATTEN_OUT), 36'd16);
    check("hys16b_valid", 36'(ATTEN_VALID), 36'd1);

    // Back to 4
    win4(36'd0, 36'h200000000, 36'd1, 36'd0);
    check("back4a_atten", 36'(ATTEN_OUT), 36'd16);
    check("back4a_valid", 36'(ATTEN_VALID), 36'd0);
    win4(36'd0, 36'h200000000, 36'd1, 36'd0);
    check("back4b_atten", 36'(ATTEN_OUT), 36'd4);
    check("back4b_valid", 36'(ATTEN_VALID), 36'd1);

    // Interrupted sequence 8, 4, 8 keeps the code
    win4(36'd0, 36'h400000000, 36'd1, 36'd0);
    check("seq8a_atten", 36'(ATTEN_OUT), 36'd4);
    check("seq8a_valid", 36'(ATTEN_VALID), 36'd0);
    win4(36'd0, 36'h200000000, 36'd1, 36'd0);
    check("seq4_atten", 36'(ATTEN_OUT), 36'd4);
    check("seq4_valid", 36'(ATTEN_VALID), 36'd0);
    win4(36'd0, 36'h400000000, 36'd1, 36'd0);
    check("seq8b_atten", 36'(ATTEN_OUT), 36'd4);
    check("seq8b_valid", 36'(ATTEN_VALID), 36'd0);

    // Sparse valid samples; pending 8 reaches HOLD on this window
    tick(1'b0, '0, 1'b0, 1'b0); tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 36'd3, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0); tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 36'h400000009, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0); tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 36'd7, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0); tick(1'b0, '0, 1'b0, 1'b0);
    check("sparse_busy", 36'(BUSY), 36'd1);
    check("sparse_peak_held", PEAK_OUT, 36'h400000000);
    tick(1'b1, 36'd2, 1'b0, 1'b0);
    tick(1'b1, 36'h800000000, 1'b0, 1'b0);
    check("sparse_atten", 36'(ATTEN_OUT), 36'd8);
    check("sparse_valid", 36'(ATTEN_VALID), 36'd1);
    check("sparse_peak",  PEAK_OUT, 36'h400000009);

    // Sample shown during DECIDE must not reach this window
    win4(36'd1, 36'd2, 36'd3, 36'd0);
    check("drop_peak",  PEAK_OUT, 36'd3);
    check("drop_atten", 36'(ATTEN_OUT), 36'd8);
    check("drop_valid", 36'(ATTEN_VALID), 36'd0);

    // STOP mid-window
    tick(1'b1, 36'd1, 1'b0, 1'b0);
    tick(1'b1, 36'd2, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    check("stop_busy",   36'(BUSY), 36'd0);
    check("stop_locked", 36'(LOCKED), 36'd0);
    check("stop_atten",  36'(ATTEN_OUT), 36'd8);
    check("stop_valid",  36'(ATTEN_VALID), 36'd0);

    // START with STOP in IDLE
    tick(1'b0, '0, 1'b1, 1'b1);
    check("startstop_busy", 36'(BUSY), 36'd0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("startstop_busy2", 36'(BUSY), 36'd0);

    // STOP in the DECIDE cycle
    tick(1'b0, '0, 1'b1, 1'b0);
    check("restart_busy", 36'(BUSY), 36'd1);
    tick(1'b1, 36'h800000000, 1'b0, 1'b0);
    tick(1'b1, 36'h800000000, 1'b0, 1'b0);
    tick(1'b1, 36'h800000000, 1'b0, 1'b0);
    tick(1'b1, 36'h800000000, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    check("stopdec_busy",   36'(BUSY), 36'd0);
    check("stopdec_atten",  36'(ATTEN_OUT), 36'd8);
    check("stopdec_valid",  36'(ATTEN_VALID), 36'd0);
    check("stopdec_peak",   PEAK_OUT, 36'd3);
    check("stopdec_locked", 36'(LOCKED), 36'd0);

    // All-zero window
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, 36'd0, 1'b0, 1'b0);
    tick(1'b1, 36'd0, 1'b0, 1'b0);
    tick(1'b1, 36'd0, 1'b0, 1'b0);
    tick(1'b1, 36'd0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("zero_atten",  36'(ATTEN_OUT), 36'd2);
    check("zero_peak",   PEAK_OUT, 36'd0);
    check("zero_valid",  36'(ATTEN_VALID), 36'd1);
    check("zero_locked", 36'(LOCKED), 36'd1);

    // Asynchronous reset mid-MEASURE with a nonzero running peak
    tick(1'b1, 36'h800000000, 1'b0, 1'b0);
    tick(1'b1, 36'd5, 1'b0, 1'b0);
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    #2;
    RESET = 1'b0;
    #1;
    check("arst_atten",  36'(ATTEN_OUT), 36'd16);
    check("arst_valid",  36'(ATTEN_VALID), 36'd0);
    check("arst_locked", 36'(LOCKED), 36'd0);
    check("arst_busy",   36'(BUSY), 36'd0);
    check("arst_peak",   PEAK_OUT, 36'd0);
    @(negedge CLK);
    RESET = 1'b1;
    tick(1'b0, '0, 1'b0, 1'b0);
    check("arst_idle_busy", 36'(BUSY), 36'd0);
    tick(1'b1, 36'h800000000, 1'b0, 1'b0);
    check("arst_nostart_busy", 36'(BUSY), 36'd0);

    // Fresh lock after reset: window counting starts from zero
    tick(1'b0, '0, 1'b1, 1'b0);
    win4(36'd0, 36'd0, 36'd1, 36'd0);
    check("relock_atten", 36'(ATTEN_OUT), 36'd2);
    check("relock_valid", 36'(ATTEN_VALID), 36'd1);
    check("relock_peak",  PEAK_OUT, 36'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound against a stalled run
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_atten_ctrl.md
Name: rx_atten_ctrl

Overview:
- Automatic attenuation controller for the text receiver.
- Watches the raw received sample stream (36-bit unsigned) over fixed-length measurement windows and records the peak of each window.
- Picks the attenuation code (16/8/4/2) that the receiver's attenuation-correction stage consumes on its 5-bit ATTEN_IN input.
- Applies hysteresis so the code only changes after a stable, repeated decision.
- Sits between the channel output and the receiver, driving the receiver's ATTEN_IN.

Parameters:
- WINDOW, 64: accepted samples per measurement window; legal range 2..1024.
- HOLD_WINDOWS, 2: consecutive identical differing decisions needed to change the code once locked; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  begin acquisition; sampled only in IDLE.
- STOP  in  1  abort and return to IDLE; accepted in any state.
- SAMPLE_VALID  in  1  SIGNAL_IN holds a new sample this cycle.
- SIGNAL_IN  in  36  received sample, unsigned.
- ATTEN_OUT  out  5  attenuation code; always one of 16, 8, 4, 2.
- ATTEN_VALID  out  1  one-cycle pulse when ATTEN_OUT is written.
- LOCKED  out  1  a decision has been made since the last START.
- BUSY  out  1  controller not in IDLE.
- PEAK_OUT  out  36  peak of the last completed window.

Behaviour:
- Reset (RESET=0, asynchronous, any time including mid-window):
  - ATTEN_OUT=5'd16; ATTEN_VALID=0; LOCKED=0; BUSY=0; PEAK_OUT=0.
  - State=IDLE; sample count, running peak, pending code and pending count all cleared.
  - Normal operation resumes on the first CLK edge after RESET returns high.
- FSM states: IDLE, MEASURE, DECIDE.
- IDLE:
  - BUSY=0.
  - START=1 and STOP=0: go to MEASURE at the next edge with peak=0 and count=0.
  - STOP=1 in IDLE: stay in IDLE.
- MEASURE:
  - BUSY=1.
  - On each edge with SAMPLE_VALID=1: peak <= max(peak, SIGNAL_IN) (unsigned compare) and count <= count+1.
  - When the accepted sample is the WINDOW-th one, go to DECIDE at that same edge; that sample is included in the peak.
  - Cycles with SAMPLE_VALID=0 do not change peak or count.
- DECIDE (exactly one cycle):
  - SAMPLE_VALID is ignored; samples presented this cycle are dropped.
  - Candidate code, by priority: peak[35]=1 gives 16; else peak[34]=1 gives 8; else peak[33]=1 gives 4; else 2. An all-zero window gives 2.
  - At the exiting edge:
    - PEAK_OUT <= peak.
    - Return to MEASURE with peak=0 and count=0.
    - Apply the code-update rules below.
- Code-update rules (evaluated at the DECIDE exiting edge):
  - LOCKED=0: ATTEN_OUT <= candidate, LOCKED <= 1, ATTEN_VALID pulses. This happens even if the candidate equals the current ATTEN_OUT. Pending state is cleared.
  - LOCKED=1 and candidate == ATTEN_OUT: clear pending count; no pulse.
  - LOCKED=1, candidate differs, candidate == pending code and pending count+1 == HOLD_WINDOWS: ATTEN_OUT <= candidate, ATTEN_VALID pulses, pending cleared.
  - LOCKED=1, candidate differs, candidate == pending code and pending count+1 < HOLD_WINDOWS: pending count++.
  - LOCKED=1, candidate differs from both ATTEN_OUT and the pending code: pending code <= candidate, pending count <= 1. If HOLD_WINDOWS==1, apply immediately with a pulse instead.
- Latency: ATTEN_OUT and PEAK_OUT change 2 edges after the edge that accepts the last sample of the window. The first edge enters DECIDE; the second applies the update.
- STOP:
  - In MEASURE or DECIDE: go to IDLE at the next edge, clear LOCKED, pending state, count and peak, and set BUSY=0.
  - ATTEN_OUT and PEAK_OUT keep their last values.
  - STOP has priority over the DECIDE update: no update and no pulse on that edge.
- START while BUSY=1: ignored. START held high continuously causes no re-trigger.
- Simultaneous START and STOP in IDLE: stay in IDLE.
- Count and peak never wrap within a window; count is cleared at every window boundary.

Test Plan:
1. Reset: drive RESET=0 mid-MEASURE with peak nonzero -> outputs immediately ATTEN_OUT=16, ATTEN_VALID=0, LOCKED=0, BUSY=0, PEAK_OUT=0; after release, the controller waits in IDLE.
2. First lock (WINDOW=4): START, then 4 valid samples 1, 36'h200000000, 5, 0 -> 2 edges after the 4th sample: ATTEN_OUT=4, ATTEN_VALID high for 1 cycle, LOCKED=1, PEAK_OUT=36'h200000000.
3. Hysteresis (WINDOW=4, HOLD_WINDOWS=2, locked at 4), bit-35 peak windows:
   - One window with peak 36'h800000000 -> no change, no pulse.
   - A second such window -> ATTEN_OUT=16 with a pulse.
   - Window sequence 8, 4, 8 (peaks 36'h400000000, 36'h200000000, 36'h400000000) -> ATTEN_OUT stays 4, no pulses.
4. Sparse valid: SAMPLE_VALID high every 3rd cycle -> DECIDE entered only after the 4th valid sample; samples presented during the DECIDE cycle do not appear in the next window's peak.
5. STOP:
   - After 2 samples of the second window -> IDLE next edge, LOCKED=0, BUSY=0, ATTEN_OUT held at its last value, no ATTEN_VALID pulse.
   - STOP asserted in the DECIDE cycle -> no update.
   - START and STOP together in IDLE -> remains IDLE.
6. Zero input: window of all-zero samples after START -> ATTEN_OUT=2, PEAK_OUT=0, ATTEN_VALID pulse, LOCKED=1.
